// File: rtl/dmem_responder.sv
// Data-memory responder: block-RAM backed load/store target with byte-lane alignment.
// Latency: load data 1+READ_WAIT cycles after accept; stores commit at the accept edge.
// Backpressure: mem_ready is low during read wait states and for WRITE_WAIT cycles after a store.
module dmem_responder #(
    parameter int ADDR_WIDTH = 14,
    parameter int READ_WAIT  = 0,
    parameter int WRITE_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic        mem_oe,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_we,
    output logic [31:0] mem_rdata,
    output logic        mem_valid,
    output logic        mem_ready,
    output logic        misalign
);

    typedef enum logic [1:0] {
        IDLE,
        RWAIT,
        RESP,
        WWAIT
    } state_t;

    localparam logic [3:0] RW_LOAD = (READ_WAIT  > 0) ? 4'(READ_WAIT  - 1) : 4'd0;
    localparam logic [3:0] WW_LOAD = (WRITE_WAIT > 0) ? 4'(WRITE_WAIT - 1) : 4'd0;

    state_t state, state_n;
    logic [3:0] cnt, cnt_n;

    logic [31:0] ram [2**ADDR_WIDTH];
    logic [31:0] rd_word;
    logic [1:0]  shift_q;
    logic        rd_mis_q;
    logic        misalign_q;

    logic [ADDR_WIDTH-1:0] widx;
    logic [1:0]  lane;
    logic        is_read;
    logic        accept;
    logic        mis_req;
    logic        wr_en;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        unused_addr;

    assign unused_addr = ^mem_addr[31:ADDR_WIDTH+2];

    assign widx    = mem_addr[ADDR_WIDTH+1:2];
    assign lane    = mem_addr[1:0];
    assign is_read = (mem_we == 4'b0000);

    assign mem_ready = ((state == IDLE) || (state == RESP)) && !rst;
    assign accept    = mem_oe && mem_ready;

    // Size is invisible on reads, so only an offset of 3 can be called misaligned there.
    always_comb begin
        mis_req = 1'b0;
        if (is_read)
            mis_req = (lane == 2'b11);
        else if (mem_we == 4'b0011)
            mis_req = lane[0];
        else if (mem_we == 4'b1111)
            mis_req = (lane != 2'b00);
    end

    assign wr_en = accept && !is_read && !mis_req;
    assign be    = mem_we << lane;
    assign wd    = mem_wdata << {lane, 3'b000};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    ram[widx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
        if (accept && is_read)
            rd_word <= ram[widx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            shift_q    <= 2'b00;
            rd_mis_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            misalign_q <= accept && mis_req;
            if (accept && is_read) begin
                shift_q  <= lane;
                rd_mis_q <= mis_req;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE, RESP: begin
                state_n = IDLE;
                if (accept) begin
                    if (is_read) begin
                        if (READ_WAIT == 0) begin
                            state_n = RESP;
                        end else begin
                            state_n = RWAIT;
                            cnt_n   = RW_LOAD;
                        end
                    end else if (WRITE_WAIT != 0) begin
                        state_n = WWAIT;
                        cnt_n   = WW_LOAD;
                    end
                end
            end
            RWAIT: begin
                if (cnt == 4'd0)
                    state_n = RESP;
                else
                    cnt_n = cnt - 4'd1;
            end
            WWAIT: begin
                if (cnt == 4'd0)
                    state_n = IDLE;
                else
                    cnt_n = cnt - 4'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    assign mem_valid = (state == RESP) && !rst;
    assign mem_rdata = (mem_valid && !rd_mis_q) ? (rd_word >> {shift_q, 3'b000}) : 32'd0;
    assign misalign  = misalign_q && !rst;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: dut0 has no wait states, dut1 has READ_WAIT=3 / WRITE_WAIT=2.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        oe0, oe1;

    logic [31:0] rdata0, rdata1;
    logic        valid0, valid1, ready0, ready1, mis0, mis1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(14), .READ_WAIT(0), .WRITE_WAIT(0)) dut0 (
        .clk(clk), .rst(rst), .mem_addr(addr), .mem_oe(oe0), .mem_wdata(wdata),
        .mem_we(we), .mem_rdata(rdata0), .mem_valid(valid0), .mem_ready(ready0),
        .misalign(mis0)
    );

    dmem_responder #(.ADDR_WIDTH(14), .READ_WAIT(3), .WRITE_WAIT(2)) dut1 (
        .clk(clk), .rst(rst), .mem_addr(addr), .mem_oe(oe1), .mem_wdata(wdata),
        .mem_we(we), .mem_rdata(rdata1), .mem_valid(valid1), .mem_ready(ready1),
        .misalign(mis1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req0(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        addr = a; we = w; wdata = d; oe0 = 1'b1;
        tick();
        oe0 = 1'b0; we = 4'b0000;
    endtask

    task automatic req1(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        addr = a; we = w; wdata = d; oe1 = 1'b1;
        tick();
        oe1 = 1'b0; we = 4'b0000;
    endtask

    initial begin
        rst = 1'b1; oe0 = 1'b0; oe1 = 1'b0; addr = '0; wdata = '0; we = '0;
        tick();
        tick();
        chk("rst_ready0", 32'(ready0), 32'd0);
        chk("rst_valid0", 32'(valid0), 32'd0);
        chk("rst_mis0",   32'(mis0),   32'd0);
        chk("rst_ready1", 32'(ready1), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready0", 32'(ready0), 32'd1);
        chk("idle_rdata0",     rdata0,      32'd0);

        // Lane alignment, no wait states
        req0(32'h100, 4'b1111, 32'h11223344);
        chk("sw_no_valid", 32'(valid0), 32'd0);
        req0(32'h100, 4'b0000, 32'h0);
        chk("rd100_valid", 32'(valid0), 32'd1);
        chk("rd100_data",  rdata0,      32'h11223344);
        req0(32'h102, 4'b0000, 32'h0);
        chk("rd102_data",  rdata0,      32'h00001122);
        chk("rd102_mis",   32'(mis0),   32'd0);
        tick();
        chk("resp_end_valid", 32'(valid0), 32'd0);
        chk("resp_end_rdata", rdata0,      32'd0);

        // Byte store into lane 3
        req0(32'h103, 4'b0001, 32'h000000AB);
        chk("sb_mis", 32'(mis0), 32'd0);
        req0(32'h100, 4'b0000, 32'h0);
        chk("sb_rd100", rdata0, 32'hAB223344);
        // Offset-3 read is flagged misaligned and returns zero data
        req0(32'h103, 4'b0000, 32'h0);
        chk("rd103_valid", 32'(valid0), 32'd1);
        chk("rd103_mis",   32'(mis0),   32'd1);
        chk("rd103_data",  rdata0,      32'd0);
        tick();
        chk("rd103_mis_pulse", 32'(mis0), 32'd0);

        // Back-to-back reads
        req0(32'h0, 4'b1111, 32'hA0A0A0A0);
        req0(32'h4, 4'b1111, 32'hA4A4A4A4);
        req0(32'h8, 4'b1111, 32'hA8A8A8A8);
        req0(32'h0, 4'b0000, 32'h0);
        chk("b2b0_valid", 32'(valid0), 32'd1);
        chk("b2b0_data",  rdata0,      32'hA0A0A0A0);
        req0(32'h4, 4'b0000, 32'h0);
        chk("b2b1_valid", 32'(valid0), 32'd1);
        chk("b2b1_data",  rdata0,      32'hA4A4A4A4);
        req0(32'h8, 4'b0000, 32'h0);
        chk("b2b2_valid", 32'(valid0), 32'd1);
        chk("b2b2_data",  rdata0,      32'hA8A8A8A8);
        // Store accepted in the response cycle, read of the same word right after
        req0(32'h8, 4'b1111, 32'hDEADBEEF);
        chk("raw_sw_valid", 32'(valid0), 32'd0);
        req0(32'h8, 4'b0000, 32'h0);
        chk("raw_data", rdata0, 32'hDEADBEEF);

        // Misaligned stores are dropped
        req0(32'h101, 4'b0011, 32'h0000FFFF);
        chk("sh101_mis",   32'(mis0),   32'd1);
        chk("sh101_valid", 32'(valid0), 32'd0);
        req0(32'h100, 4'b0000, 32'h0);
        chk("sh101_rd",    rdata0,      32'hAB223344);
        chk("sh101_mis_clr", 32'(mis0), 32'd0);
        req0(32'h102, 4'b1111, 32'h55667788);
        chk("sw102_mis", 32'(mis0), 32'd1);
        req0(32'h100, 4'b0000, 32'h0);
        chk("sw102_rd", rdata0, 32'hAB223344);

        // Request under reset is ignored
        tick();
        rst = 1'b1;
        addr = 32'h100; we = 4'b1111; wdata = 32'h0; oe0 = 1'b1;
        #1;
        chk("rst_oe_ready", 32'(ready0), 32'd0);
        tick();
        rst = 1'b0; oe0 = 1'b0; we = 4'b0000;
        req0(32'h100, 4'b0000, 32'h0);
        chk("rst_oe_rd", rdata0, 32'hAB223344);
        tick();

        // Write wait states
        req1(32'h40, 4'b1111, 32'hCAFEF00D);
        chk("ww_c1_ready", 32'(ready1), 32'd0);
        tick();
        chk("ww_c2_ready", 32'(ready1), 32'd0);
        tick();
        chk("ww_c3_ready", 32'(ready1), 32'd1);

        // Read wait states: response lands four cycles after accept
        req1(32'h40, 4'b0000, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rw_wait%0d_ready", i), 32'(ready1), 32'd0);
            chk($sformatf("rw_wait%0d_valid", i), 32'(valid1), 32'd0);
            tick();
        end
        chk("rw_valid", 32'(valid1), 32'd1);
        chk("rw_data",  rdata1,      32'hCAFEF00D);
        chk("rw_ready", 32'(ready1), 32'd1);
        tick();
        chk("rw_valid_end", 32'(valid1), 32'd0);

        // Reset in the middle of a read wait
        req1(32'h40, 4'b0000, 32'h0);
        tick();
        rst = 1'b1;
        #1;
        chk("rstw_ready", 32'(ready1), 32'd0);
        chk("rstw_valid", 32'(valid1), 32'd0);
        tick();
        chk("rstw_valid2", 32'(valid1), 32'd0);
        rst = 1'b0;
        #1;
        chk("rstw_ready_after", 32'(ready1), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rstw_novalid%0d", i), 32'(valid1), 32'd0);
        end
        req1(32'h40, 4'b0000, 32'h0);
        begin
            int n;
            n = 0;
            while (!valid1 && n < 8) begin
                tick();
                n++;
            end
            chk("rstw_ram_valid", 32'(valid1), 32'd1);
            chk("rstw_ram_lat",   32'(n),      32'd3);
            chk("rstw_ram_data",  rdata1,      32'hCAFEF00D);
        end
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
